mmio_periph_ctrl: RTL and testbench

//  Parametrised MMIO peripheral block on the riscv data port, next to the byte-addressed data RAM.

---
 rtl/mmio_pkg.sv | 38 +++
 rtl/mmio_disp_fsm.sv | 67 ++++++
 rtl/mmio_periph_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mmio_periph_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO peripheral block: register offsets,
// STATUS/CTRL bit positions, display FSM state type and a byte-lane merge helper.
package mmio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 12;

  // Byte offsets within the decoded 4 KB page
  localparam logic [OFF_W-1:0] OFF_ID       = 12'h000;
  localparam logic [OFF_W-1:0] OFF_CTRL     = 12'h004;
  localparam logic [OFF_W-1:0] OFF_DISP_DAT = 12'h008;
  localparam logic [OFF_W-1:0] OFF_LED      = 12'h00C;
  localparam logic [OFF_W-1:0] OFF_STATUS   = 12'h010;
  localparam logic [OFF_W-1:0] OFF_GPO0     = 12'h014;
  localparam logic [OFF_W-1:0] OFF_CNT_LO   = 12'h020;
  localparam logic [OFF_W-1:0] OFF_CNT_HI   = 12'h024;

  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_OVR_BIT  = 1;
  localparam int unsigned CTRL_GO_BIT     = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } disp_state_t;

  // Replace the bytes of old_v selected by en with the matching bytes of new_v
  function automatic logic [DATA_W-1:0] apply_lanes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [3:0]        en);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = en[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_disp_fsm.sv
// Display valid/ready handshake: IDLE/SEND FSM, shadow data frozen at GO,
// sticky overrun flag for GO seen while a transfer is still pending.
// Ports: clk, Rst (sync, active-high), go, clr_ovr, dat_in (live DISP_DAT),
//        disp_ready in; disp_valid, disp_dat, busy_c (comb), overrun out.
module mmio_disp_fsm
  import mmio_pkg::*;
(
  input  logic              clk,
  input  logic              Rst,
  input  logic              go,
  input  logic              clr_ovr,
  input  logic [DATA_W-1:0] dat_in,
  input  logic              disp_ready,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_dat,
  output logic              busy_c,
  output logic              overrun
);

  disp_state_t       state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              ovr_q, ovr_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      shadow_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      shadow_q <= shadow_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next state; overrun set is applied after clear so set wins
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ovr_d    = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = SEND;
          shadow_d = dat_in;
        end
      end
      SEND: begin
        if (go)         ovr_d   = 1'b1;
        if (disp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == SEND);
  end

  assign disp_valid = valid_q;
  assign disp_dat   = shadow_q;
  assign busy_c     = (state_q == SEND);
  assign overrun    = ovr_q;

endmodule

// File: rtl/mmio_periph_ctrl.sv
// MMIO peripheral block on the data port: decodes one 4 KB page into ID, CTRL,
// DISP_DAT, LED, STATUS and NUM_GPO GPO registers, with 1-cycle read latency.
// Optional 64-bit cycle counter at 0x020/0x024 when MMIO_CYCLE_CNT_EN is defined.
// Ports: clk, Rst (sync, active-high); mem_wea/mem_en/mem_addr/mem_din bus in;
//        mmio_hit (comb), mmio_dout, mmio_rvalid read side; disp_valid/disp_ready/
//        disp_dat display handshake; led, gpo register outputs.
module mmio_periph_ctrl
  import mmio_pkg::*;
#(
  parameter logic [19:0] BASE_PAGE = 20'hAAAAA,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned NUM_GPO   = 2,
  parameter logic [31:0] ID_VALUE  = 32'h4D494F32
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              mem_wea,
  input  logic [3:0]        mem_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_din,
  output logic              mmio_hit,
  output logic [31:0]       mmio_dout,
  output logic              mmio_rvalid,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [31:0]       disp_dat,
  output logic [LED_W-1:0]  led,
  output logic [((NUM_GPO == 0) ? 1 : NUM_GPO*32)-1:0] gpo
);

  localparam int unsigned GPO_N = (NUM_GPO == 0) ? 1 : NUM_GPO;

  logic              wr_c, rd_c, go_c, clr_ovr_c, busy_c, overrun;
  logic [OFF_W-1:0]  off_c;
  logic [9:0]        gpo_word_c;
  logic              gpo_sel_c;
  logic [31:0]       led_merge_c, rdata_c;
  logic              unused_bits;

  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       disp_reg_q, disp_reg_d;
  logic [31:0]       gpo_q [GPO_N];
  logic [31:0]       gpo_d [GPO_N];
  logic [31:0]       mmio_dout_q, mmio_dout_d;
  logic              rvalid_q, rvalid_d;

  // Address decode; addr[1:0] do not participate
  assign mmio_hit   = (mem_addr[31:12] == BASE_PAGE) && (mem_en != 4'b0000);
  assign wr_c       = mmio_hit && mem_wea;
  assign rd_c       = mmio_hit && !mem_wea;
  assign off_c      = {mem_addr[11:2], 2'b00};
  assign gpo_word_c = 10'((off_c - OFF_GPO0) >> 2);
  assign gpo_sel_c  = (off_c >= OFF_GPO0) && (32'(gpo_word_c) < NUM_GPO);
  assign unused_bits = ^{mem_addr[1:0], led_merge_c};

`ifdef MMIO_CYCLE_CNT_EN
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;

  // Free-running counter; reading the low word snapshots the high word
  always_comb begin
    cnt_d  = cnt_q + 64'd1;
    snap_d = snap_q;
    if (wr_c && off_c == OFF_CNT_LO) cnt_d  = '0;
    if (rd_c && off_c == OFF_CNT_LO) snap_d = cnt_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end
`endif

  // Byte-lane register writes, GO pulse and overrun clear strobe
  always_comb begin
    led_d       = led_q;
    disp_reg_d  = disp_reg_q;
    gpo_d       = gpo_q;
    go_c        = 1'b0;
    clr_ovr_c   = 1'b0;
    led_merge_c = apply_lanes(32'(led_q), mem_din, mem_en);
    if (wr_c) begin
      case (off_c)
        OFF_CTRL:     go_c       = mem_en[0] && mem_din[CTRL_GO_BIT];
        OFF_DISP_DAT: disp_reg_d = apply_lanes(disp_reg_q, mem_din, mem_en);
        OFF_LED:      led_d      = led_merge_c[LED_W-1:0];
        OFF_STATUS:   clr_ovr_c  = mem_en[0] && mem_din[STATUS_OVR_BIT];
        default:      ;
      endcase
    end
    for (int k = 0; k < int'(NUM_GPO); k++) begin
      if (wr_c && gpo_sel_c && gpo_word_c == 10'(k)) begin
        gpo_d[k] = apply_lanes(gpo_q[k], mem_din, mem_en);
      end
    end
  end

  // Read mux; unmapped and write-only offsets return 0
  always_comb begin
    rdata_c = '0;
    case (off_c)
      OFF_ID:       rdata_c = ID_VALUE;
      OFF_DISP_DAT: rdata_c = disp_reg_q;
      OFF_LED:      rdata_c = 32'(led_q);
      OFF_STATUS: begin
        rdata_c[STATUS_BUSY_BIT] = busy_c;
        rdata_c[STATUS_OVR_BIT]  = overrun;
      end
`ifdef MMIO_CYCLE_CNT_EN
      OFF_CNT_LO:   rdata_c = cnt_q[31:0];
      OFF_CNT_HI:   rdata_c = snap_q;
`endif
      default:      rdata_c = '0;
    endcase
    for (int k = 0; k < int'(NUM_GPO); k++) begin
      if (gpo_sel_c && gpo_word_c == 10'(k)) rdata_c = gpo_q[k];
    end
    mmio_dout_d = rd_c ? rdata_c : mmio_dout_q;
    rvalid_d    = rd_c;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      led_q       <= '0;
      disp_reg_q  <= '0;
      mmio_dout_q <= '0;
      rvalid_q    <= 1'b0;
      for (int k = 0; k < int'(GPO_N); k++) gpo_q[k] <= '0;
    end else begin
      led_q       <= led_d;
      disp_reg_q  <= disp_reg_d;
      mmio_dout_q <= mmio_dout_d;
      rvalid_q    <= rvalid_d;
      gpo_q       <= gpo_d;
    end
  end

  mmio_disp_fsm u_disp_fsm (
    .clk        (clk),
    .Rst        (Rst),
    .go         (go_c),
    .clr_ovr    (clr_ovr_c),
    .dat_in     (disp_reg_q),
    .disp_ready (disp_ready),
    .disp_valid (disp_valid),
    .disp_dat   (disp_dat),
    .busy_c     (busy_c),
    .overrun    (overrun)
  );

  // Flatten GPO registers onto the output bus
  always_comb begin
    gpo = '0;
    for (int k = 0; k < int'(NUM_GPO); k++) gpo[32*k +: 32] = gpo_q[k];
  end

  assign led         = led_q;
  assign mmio_dout   = mmio_dout_q;
  assign mmio_rvalid = rvalid_q;

endmodule

// File: tb/tb_mmio_periph_ctrl.sv
// Self-checking bench for mmio_periph_ctrl: read responses are checked by a
// scoreboard monitor; display/LED/GPO outputs are checked directly.
module tb_mmio_periph_ctrl;

  localparam logic [31:0] BASE = 32'hAAAAA000;
  localparam logic [31:0] ID   = 32'h4D494F32;

  logic        clk = 1'b0;
  logic        Rst;
  logic        mem_wea;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mmio_hit;
  logic [31:0] mmio_dout;
  logic        mmio_rvalid;
  logic        disp_valid;
  logic        disp_ready;
  logic [31:0] disp_dat;
  logic [15:0] led;
  logic [63:0] gpo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mmio_periph_ctrl dut (
    .clk         (clk),
    .Rst         (Rst),
    .mem_wea     (mem_wea),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mmio_hit    (mmio_hit),
    .mmio_dout   (mmio_dout),
    .mmio_rvalid (mmio_rvalid),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_dat    (disp_dat),
    .led         (led),
    .gpo         (gpo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rvalid pops one expected read value
  always @(negedge clk) begin
    if (mmio_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected dout=%h", mmio_dout);
      end else begin
        chk("read_data", 64'(mmio_dout), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d, input logic [3:0] en);
    mem_addr = BASE | 32'(off);
    mem_din  = d;
    mem_en   = en;
    mem_wea  = 1'b1;
    step();
    mem_en   = 4'b0000;
    mem_wea  = 1'b0;
  endtask

  task automatic rd(input logic [11:0] off, input logic [31:0] exp);
    exp_q.push_back(exp);
    mem_addr = BASE | 32'(off);
    mem_en   = 4'b1111;
    mem_wea  = 1'b0;
    step();
    mem_en   = 4'b0000;
  endtask

  initial begin
    Rst = 1'b1; mem_wea = 1'b0; mem_en = 4'b0000; mem_addr = '0; mem_din = '0;
    disp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 Rst = 1'b0;

    // Reset state
    samp();
    chk("rst_led", 64'(led), 64'h0);
    chk("rst_gpo", gpo, 64'h0);
    chk("rst_valid", 64'(disp_valid), 64'h0);
    chk("rst_dat", 64'(disp_dat), 64'h0);
    chk("rst_rvalid", 64'(mmio_rvalid), 64'h0);
    step();

    // ID read with hit; off-page read misses
    exp_q.push_back(ID);
    mem_addr = BASE; mem_en = 4'b1111; mem_wea = 1'b0;
    #1 chk("hit_id", 64'(mmio_hit), 64'h1);
    step();
    mem_addr = 32'h00000040;
    #1 chk("hit_miss", 64'(mmio_hit), 64'h0);
    step();
    mem_en = 4'b0000;
    samp();
    chk("miss_rvalid", 64'(mmio_rvalid), 64'h0);
    chk("miss_dout_hold", 64'(mmio_dout), 64'(ID));
    step();

    // LED byte lanes and truncation
    wr(12'h00C, 32'hFFFF1234, 4'b0001);
    samp(); chk("led_lane0", 64'(led), 64'h0034); step();
    wr(12'h00C, 32'h0000AB00, 4'b0010);
    samp(); chk("led_lane1", 64'(led), 64'hAB34); step();
    rd(12'h00C, 32'h0000AB34);

    // Display transfer held off by ready=0
    wr(12'h008, 32'h00000011, 4'b1111);
    wr(12'h004, 32'h00000001, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      samp();
      chk("send_valid", 64'(disp_valid), 64'h1);
      chk("send_dat", 64'(disp_dat), 64'h11);
      step();
    end
    rd(12'h010, 32'h1);

    // DISP_DAT write and GO during SEND
    wr(12'h008, 32'h00000022, 4'b1111);
    wr(12'h004, 32'h00000001, 4'b0001);
    samp(); chk("frozen_dat", 64'(disp_dat), 64'h11); step();
    rd(12'h010, 32'h3);
    rd(12'h008, 32'h22);
    wr(12'h010, 32'h00000002, 4'b1111);
    rd(12'h010, 32'h1);

    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;
    samp(); chk("done_valid", 64'(disp_valid), 64'h0); step();

    // New GO picks up the updated DISP_DAT
    wr(12'h004, 32'h00000001, 4'b0001);
    samp();
    chk("go2_valid", 64'(disp_valid), 64'h1);
    chk("go2_dat", 64'(disp_dat), 64'h22);
    step();

    // GO together with ready in SEND: completes and flags overrun
    disp_ready = 1'b1;
    wr(12'h004, 32'h00000001, 4'b0001);
    disp_ready = 1'b0;
    samp(); chk("goready_valid", 64'(disp_valid), 64'h0); step();
    rd(12'h010, 32'h2);
    wr(12'h010, 32'h00000002, 4'b0001);
    rd(12'h010, 32'h0);

    // GPO lanes, unmapped write, back-to-back reads
    wr(12'h014, 32'hDEADBEEF, 4'b1111);
    wr(12'h018, 32'h12345678, 4'b1100);
    samp(); chk("gpo_bus", gpo, 64'h12340000_DEADBEEF); step();
    wr(12'h0FC, 32'h55555555, 4'b1111);
    rd(12'h014, 32'hDEADBEEF);
    rd(12'h018, 32'h12340000);
    rd(12'h0FC, 32'h0);

    // CTRL reads 0, ID is read-only
    rd(12'h004, 32'h0);
    wr(12'h000, 32'h00000000, 4'b1111);
    rd(12'h000, ID);
`ifndef MMIO_CYCLE_CNT_EN
    rd(12'h020, 32'h0);
    rd(12'h024, 32'h0);
`endif

    // Reset in the middle of a transfer
    wr(12'h004, 32'h00000001, 4'b0001);
    samp(); chk("pre_rst_valid", 64'(disp_valid), 64'h1); step();
    Rst = 1'b1;
    step();
    samp();
    chk("midrst_valid", 64'(disp_valid), 64'h0);
    chk("midrst_led", 64'(led), 64'h0);
    chk("midrst_gpo", gpo, 64'h0);
    step();
    Rst = 1'b0;
    rd(12'h010, 32'h0);
    wr(12'h004, 32'h00000001, 4'b0001);
    samp();
    chk("restart_valid", 64'(disp_valid), 64'h1);
    chk("restart_dat", 64'(disp_dat), 64'h0);
    step();
    disp_ready = 1'b1;
    step();
    disp_ready = 1'b0;

    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
